// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multiport register file.
// Optional feature macro: MULTIPORT_REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 3;

  // Range test kept in a function so that, for power-of-2 depths, the
  // comparison is not folded into a constant-result warning at the call site.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_init_fsm.sv
// Sequencer for the register file: clears every entry after reset, waits in
// LOAD for the initial image, then enters RUN where normal writes and reads work.
module regfile_init_fsm
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              ld_done,
  output state_t            state,
  output logic [ADDR_W-1:0] clr_cnt,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              ready_reg;

  // State, clear counter and ready flag advance together so ready is registered.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (clr_cnt_reg == LAST_ADDR) begin
            state_reg   <= LOAD;
            clr_cnt_reg <= '0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        LOAD: begin
          if (ld_done) begin
            state_reg <= RUN;
            ready_reg <= 1'b1;
          end
        end
        RUN: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg   <= CLEAR;
          clr_cnt_reg <= '0;
          ready_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign state   = state_reg;
  assign clr_cnt = clr_cnt_reg;
  assign ready   = ready_reg;

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file: two write ports, NUM_RD combinational read ports,
// a dedicated load port used once after the power-on clear sequence.
// Optional feature macro: MULTIPORT_REGFILE_BYPASS_EN forwards same-cycle
// write data to matching read ports (port 1 over port 0).
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk_50,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     ld_done,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  output logic                     ready
);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem_reg [DEPTH];

  // An address is live when it maps to a real entry and is not the hardwired zero.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return addr_in_range(32'(a), DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_init_fsm #(
    .DEPTH (DEPTH)
  ) u_init_fsm (
    .clk_50  (clk_50),
    .rst     (rst),
    .ld_done (ld_done),
    .state   (state),
    .clr_cnt (clr_cnt),
    .ready   (ready)
  );

  // Storage writes: clear sweep, load port, then the two run-time ports (port 1 last so it wins).
  always_ff @(posedge clk_50) begin
    if (!rst) begin
      case (state)
        CLEAR: begin
          mem_reg[clr_cnt] <= '0;
        end
        LOAD: begin
          if (ld_valid && addr_live(ld_addr)) mem_reg[ld_addr] <= ld_data;
        end
        RUN: begin
          if (we0 && addr_live(wa0)) mem_reg[wa0] <= wd0;
          if (we1 && addr_live(wa1)) mem_reg[wa1] <= wd1;
        end
        default: begin
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rdata;

      assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

      // Zero-latency read; forced to zero until the file is ready or for dead addresses.
      always_comb begin
        rdata = '0;
        if (ready && addr_live(ra)) begin
          rdata = mem_reg[ra];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
          // A write being dropped by reset must not be forwarded either.
          if (!rst && we0 && (wa0 == ra)) rdata = wd0;
          if (!rst && we1 && (wa1 == ra)) rdata = wd1;
`endif
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = rdata;
    end
  endgenerate

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed, table-driven bench for multiport_regfile (DATA_W=32, DEPTH=32, NUM_RD=3).
module tb_multiport_regfile;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic        we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic        we1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic        ready;

  int checks = 0;
  int errors = 0;

  always #5 clk_50 = ~clk_50;

  multiport_regfile dut (
    .clk_50   (clk_50),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_done  (ld_done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .ready    (ready)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk_50);
    #2;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  // Counts edges after the reset edge until ready rises (0 if it never does).
  task automatic cycles_to_ready(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] exp_byp;

    vecs[0] = '{1'b1, 5'd1,  32'h1111_1111, 1'b1, 5'd2,  32'h2222_2222, 5'd1,  5'd2, 5'd3,  32'h0,         32'h0,         32'h0};
    vecs[1] = '{1'b1, 5'd7,  32'h0000_0011, 1'b1, 5'd7,  32'h0000_0022, 5'd1,  5'd2, 5'd0,  32'h1111_1111, 32'h2222_2222, 32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd7,  5'd1, 5'd2,  32'h22,        32'h1111_1111, 32'h2222_2222};
    vecs[3] = '{1'b1, 5'd0,  32'h0000_FFFF, 1'b0, 5'd0,  32'h0,         5'd7,  5'd7, 5'd7,  32'h22,        32'h22,        32'h22};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd0,  5'd0, 5'd0,  32'h0,         32'h0,         32'h0};
    vecs[5] = '{1'b1, 5'd30, 32'h3030_3030, 1'b1, 5'd31, 32'hCAFE_F00D, 5'd0,  5'd1, 5'd7,  32'h0,         32'h1111_1111, 32'h22};
    vecs[6] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd31, 5'd30, 5'd2, 32'hCAFE_F00D, 32'h3030_3030, 32'h2222_2222};
    vecs[7] = '{1'b1, 5'd1,  32'h0000_AAAA, 1'b1, 5'd1,  32'h0000_BBBB, 5'd31, 5'd0, 5'd30, 32'hCAFE_F00D, 32'h0,         32'h3030_3030};
    vecs[8] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd1,  5'd7, 5'd31, 32'h0000_BBBB, 32'h22,        32'hCAFE_F00D};

    // Reset and clear with ld_done held high from the start.
    idle_inputs();
    set_rd(5'd1, 5'd2, 5'd3);
    rst = 1'b1;
    tick();
    check("reset_ready", 96'(ready), 96'(0));
    check("reset_rd_data", rd_data, 96'h0);
    rst = 1'b0;
    ld_done = 1'b1;
    cycles_to_ready(n);
    check("first_ready_cycle", 96'(n), 96'(33));
    $display("txn reset_clear ready_after=%0d", n);
    ld_done = 1'b0;
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(a), 5'(a));
      #1;
      check($sformatf("cleared_%0d", a), rd_data, 96'h0);
    end

    // Table-driven run-time writes; reads never touch a same-cycle write address.
    for (int i = 0; i < 9; i++) begin
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      set_rd(vecs[i].ra0, vecs[i].ra1, vecs[i].ra2);
      #1;
      $display("txn vec%0d rd_addr=%h rd_data=%h", i, rd_addr, rd_data);
      check($sformatf("vec%0d", i), rd_data, {vecs[i].e2, vecs[i].e1, vecs[i].e0});
      tick();
    end
    idle_inputs();

    // Same-cycle write and read of addr 3 on read port 2.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5;
    set_rd(5'd0, 5'd0, 5'd3);
    #1;
`ifdef MULTIPORT_REGFILE_BYPASS_EN
    exp_byp = 32'hA5;
`else
    exp_byp = 32'h0;
`endif
    check("bypass_same_cycle", rd_data, {exp_byp, 32'h0, 32'h0});
    $display("txn bypass same_cycle rd_data=%h", rd_data);
    tick();
    we0 = 1'b0;
    #1;
    check("bypass_next_cycle", rd_data, {32'hA5, 32'h0, 32'h0});

    // Load port must be ignored in RUN.
    ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'h4444_4444; ld_done = 1'b1;
    tick();
    idle_inputs();
    set_rd(5'd4, 5'd0, 5'd0);
    #1;
    check("ld_ignored_in_run", rd_data, 96'h0);
    $display("txn ld_in_run rd_data=%h", rd_data);

    // Reset in RUN with a concurrent write; clear must restart from entry 0.
    rst = 1'b1; we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66;
    set_rd(5'd6, 5'd1, 5'd31);
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    check("midreset_ready", 96'(ready), 96'(0));
    check("midreset_rd_data", rd_data, 96'h0);
    ld_done = 1'b1;
    cycles_to_ready(n);
    check("midreset_ready_cycle", 96'(n), 96'(33));
    ld_done = 1'b0;
    #1;
    check("midreset_cleared", rd_data, 96'h0);
    $display("txn midreset ready_after=%0d", n);

    // Fresh reset, stray load/write during CLEAR, then a real LOAD phase.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 20) begin
        ld_valid = 1'b1; ld_addr = 5'd12; ld_data = 32'h1212_1212;
        we0 = 1'b1; wa0 = 5'd13; wd0 = 32'h1313_1313;
      end else begin
        idle_inputs();
      end
      tick();
    end
    idle_inputs();
    check("load_wait_ready", 96'(ready), 96'(0));
    ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h99;
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h1010;
    tick();
    we0 = 1'b0;
    ld_addr = 5'd0; ld_data = 32'hFFFF;
    tick();
    check("load_still_not_ready", 96'(ready), 96'(0));
    ld_addr = 5'd5; ld_data = 32'hDEAD_BEEF; ld_done = 1'b1;
    tick();
    idle_inputs();
    check("load_done_ready", 96'(ready), 96'(1));
    set_rd(5'd5, 5'd9, 5'd0);
    #1;
    check("load_values", rd_data, {32'h0, 32'h99, 32'hDEAD_BEEF});
    $display("txn load rd_data=%h", rd_data);
    set_rd(5'd10, 5'd12, 5'd13);
    #1;
    check("ignored_writes", rd_data, 96'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
